aclk_time_counter: RTL and testbench
====================================

Name: aclk_time_counter

Overview:
- Consumer of the time generator's minute tick; holds the running clock time as four BCD digits (HH:MM).
- Advances one minute per tick and wraps at the end of the hour and the end of the day.
- Accepts a validated time-set load from the keypad/key-register path.
- Drives the display/alarm-compare path and emits an hour tick for downstream use.

Parameters:
- MODE24, 1, 1 = 24-hour range 00:00–23:59; 0 = 12-hour range 01:00–12:59.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- one_minute  input  1  minute tick from the time generator; may stay high for more than one cycle
- load_new_c  input  1  synchronous time-set strobe, one cycle
- new_ms_hr  input  4  BCD load value, hour tens digit
- new_ls_hr  input  4  BCD load value, hour units digit
- new_ms_min  input  4  BCD load value, minute tens digit
- new_ls_min  input  4  BCD load value, minute units digit
- ms_hr  output  4  current hour tens digit (BCD)
- ls_hr  output  4  current hour units digit (BCD)
- ms_min  output  4  current minute tens digit (BCD)
- ls_min  output  4  current minute units digit (BCD)
- hour_tick  output  1  one-cycle pulse when minutes wrap 59→00 by increment
- load_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- All outputs are registered.
- Reset values:
  - MODE24=1: time 00:00.
  - MODE24=0: time 12:00.
  - hour_tick=0, load_err=0, edge register=0.
- Tick detection:
  - Edge register samples one_minute every cycle.
  - inc = one_minute & ~edge_reg. Exactly one increment per rising edge, regardless of pulse width.
- Priority per cycle: reset > load_new_c > inc.
- Load path:
  - A load is valid when every digit is ≤ 9, new_ms_min ≤ 5, and the hour is in range.
  - Hour range, MODE24=1: 00–23 (ms_hr ≤ 2; if ms_hr = 2 then ls_hr ≤ 3).
  - Hour range, MODE24=0: 01–12 (ms_hr ≤ 1; ms_hr = 0 needs ls_hr ≠ 0; ms_hr = 1 needs ls_hr ≤ 2).
  - Valid load: digits appear on the outputs the next cycle.
  - Invalid load: time unchanged; load_err = 1 for one cycle.
  - An inc in the same cycle as load_new_c (valid or not) is discarded, not deferred.
- Increment path (latency: outputs change one cycle after the rising edge of one_minute is sampled):
  - ls_min 0–8: ls_min + 1.
  - ls_min = 9: ls_min → 0 and ms_min + 1.
  - ms_min:ls_min = 5:9: minutes → 00, hour + 1, hour_tick = 1 that cycle.
  - MODE24=1 hour increment: ls_hr 9 → 0 with ms_hr + 1; 23 → 00.
  - MODE24=0 hour increment: 09 → 10; 12 → 01; 11 → 12.
- hour_tick and load_err are 0 in every cycle not described above.
- A valid load never asserts hour_tick, even when it changes the hour.
- Reset mid-operation: the state returns to its reset value immediately (asynchronous). The first tick after reset release counts only if one_minute rises after release; a level already high at release is not counted.
- No illegal state is reachable. Arithmetic is per-digit 4-bit BCD with no binary carry beyond the defined wraps.

Test Plan:
- Reset with MODE24=1, then 10 one-cycle one_minute pulses → outputs 00:10, hour_tick never asserted.
- Load 23:59, then one pulse → 00:00 next cycle with hour_tick = 1 for exactly one cycle. Next pulse → 00:01, hour_tick = 0.
- MODE24=0: load 12:59, one pulse → 01:00 with hour_tick. Load 11:59, one pulse → 12:00.
- Hold one_minute high for 20 cycles from 07:30 → 07:31 only; release and re-raise → 07:32.
- Invalid loads:
  - 24:00 (MODE24=1) → load_err pulse, time unchanged.
  - 00:30 (MODE24=0) → load_err pulse, time unchanged.
  - 12:6A → load_err pulse, time unchanged.
  - Valid 09:45 → load_err = 0, outputs 09:45.
- Two collision and reset cases:
  - Assert load_new_c = 05:05 in the same cycle as a one_minute rising edge → 05:05, not 05:06.
  - Assert reset asynchronously at 15:42 mid-cycle → 00:00 immediately.

Source files
------------

// File: rtl/aclk_time_counter.sv
// aclk_time_counter: running HH:MM clock held as four BCD digits.
// Advances one minute per rising edge of the minute tick, accepts
// validated time-set loads, and pulses hour_tick on a 59->00 minute wrap.
`timescale 1ns/1ps

module aclk_time_counter #(
  parameter bit MODE24 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic       load_new_c,
  input  logic [3:0] new_ms_hr,
  input  logic [3:0] new_ls_hr,
  input  logic [3:0] new_ms_min,
  input  logic [3:0] new_ls_min,
  output logic [3:0] ms_hr,
  output logic [3:0] ls_hr,
  output logic [3:0] ms_min,
  output logic [3:0] ls_min,
  output logic       hour_tick,
  output logic       load_err
);

  // Reset time is 00:00 in 24-hour mode and 12:00 in 12-hour mode.
  localparam logic [3:0] RST_MS_HR = MODE24 ? 4'd0 : 4'd1;
  localparam logic [3:0] RST_LS_HR = MODE24 ? 4'd0 : 4'd2;

  logic       edge_reg;
  logic       armed;
  logic       inc;
  logic       hr_ok;
  logic       load_ok;
  logic       hour_wrap;
  logic [3:0] nxt_ms_hr;
  logic [3:0] nxt_ls_hr;
  logic [3:0] nxt_ms_min;
  logic [3:0] nxt_ls_min;

  // armed stays low for the first clock after reset release so that a
  // minute level already high at release is only sampled, never counted.
  assign inc = one_minute & ~edge_reg & armed;

  // Validate the requested load time against the configured hour range.
  always_comb begin
    hr_ok = 1'b0;
    if (MODE24) begin
      hr_ok = ((new_ms_hr < 4'd2) && (new_ls_hr <= 4'd9)) ||
              ((new_ms_hr == 4'd2) && (new_ls_hr <= 4'd3));
    end else begin
      hr_ok = ((new_ms_hr == 4'd0) && (new_ls_hr != 4'd0) && (new_ls_hr <= 4'd9)) ||
              ((new_ms_hr == 4'd1) && (new_ls_hr <= 4'd2));
    end
    load_ok = hr_ok && (new_ms_min <= 4'd5) && (new_ls_min <= 4'd9);
  end

  // Compute the time one minute ahead with per-digit BCD carries.
  always_comb begin
    nxt_ms_hr  = ms_hr;
    nxt_ls_hr  = ls_hr;
    nxt_ms_min = ms_min;
    nxt_ls_min = ls_min;
    hour_wrap  = 1'b0;
    if (ls_min != 4'd9) begin
      nxt_ls_min = ls_min + 4'd1;
    end else begin
      nxt_ls_min = 4'd0;
      if (ms_min != 4'd5) begin
        nxt_ms_min = ms_min + 4'd1;
      end else begin
        nxt_ms_min = 4'd0;
        hour_wrap  = 1'b1;
        if (MODE24) begin
          if ((ms_hr == 4'd2) && (ls_hr == 4'd3)) begin
            nxt_ms_hr = 4'd0;
            nxt_ls_hr = 4'd0;
          end else if (ls_hr == 4'd9) begin
            nxt_ms_hr = ms_hr + 4'd1;
            nxt_ls_hr = 4'd0;
          end else begin
            nxt_ls_hr = ls_hr + 4'd1;
          end
        end else begin
          if ((ms_hr == 4'd1) && (ls_hr == 4'd2)) begin
            nxt_ms_hr = 4'd0;
            nxt_ls_hr = 4'd1;
          end else if (ls_hr == 4'd9) begin
            nxt_ms_hr = 4'd1;
            nxt_ls_hr = 4'd0;
          end else begin
            nxt_ls_hr = ls_hr + 4'd1;
          end
        end
      end
    end
  end

  // Time register: load has priority over increment; a coincident tick is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_hr     <= RST_MS_HR;
      ls_hr     <= RST_LS_HR;
      ms_min    <= 4'd0;
      ls_min    <= 4'd0;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
      edge_reg  <= 1'b0;
      armed     <= 1'b0;
    end else begin
      edge_reg  <= one_minute;
      armed     <= 1'b1;
      hour_tick <= 1'b0;
      load_err  <= 1'b0;
      if (load_new_c) begin
        if (load_ok) begin
          ms_hr  <= new_ms_hr;
          ls_hr  <= new_ls_hr;
          ms_min <= new_ms_min;
          ls_min <= new_ls_min;
        end else begin
          load_err <= 1'b1;
        end
      end else if (inc) begin
        ms_hr     <= nxt_ms_hr;
        ls_hr     <= nxt_ls_hr;
        ms_min    <= nxt_ms_min;
        ls_min    <= nxt_ls_min;
        hour_tick <= hour_wrap;
      end
    end
  end

endmodule

// File: tb/tb_aclk_time_counter.sv
// Bench for aclk_time_counter: drives a 24-hour and a 12-hour instance from
// shared inputs; expected results go into a queue checked at each negedge.
`timescale 1ns/1ps

module tb_aclk_time_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       one_minute;
  logic       load_new_c;
  logic [3:0] new_ms_hr;
  logic [3:0] new_ls_hr;
  logic [3:0] new_ms_min;
  logic [3:0] new_ls_min;

  logic [3:0] ms_hr_24, ls_hr_24, ms_min_24, ls_min_24;
  logic       hour_tick_24, load_err_24;
  logic [3:0] ms_hr_12, ls_hr_12, ms_min_12, ls_min_12;
  logic       hour_tick_12, load_err_12;

  typedef struct {
    string       name;
    bit          sel12;
    logic [15:0] time_bcd;
    logic        ht;
    logic        le;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  logic [17:0] act;
  logic [17:0] want;
  int checks = 0;
  int errors = 0;

  aclk_time_counter #(.MODE24(1'b1)) dut24 (
    .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
    .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .ms_hr(ms_hr_24), .ls_hr(ls_hr_24), .ms_min(ms_min_24), .ls_min(ls_min_24),
    .hour_tick(hour_tick_24), .load_err(load_err_24)
  );

  aclk_time_counter #(.MODE24(1'b0)) dut12 (
    .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
    .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
    .ms_hr(ms_hr_12), .ls_hr(ls_hr_12), .ms_min(ms_min_12), .ls_min(ls_min_12),
    .hour_tick(hour_tick_12), .load_err(load_err_12)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Monitor: on each falling edge, compare every queued expectation.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      if (cur.sel12)
        act = {ms_hr_12, ls_hr_12, ms_min_12, ls_min_12, hour_tick_12, load_err_12};
      else
        act = {ms_hr_24, ls_hr_24, ms_min_24, ls_min_24, hour_tick_24, load_err_24};
      want = {cur.time_bcd, cur.ht, cur.le};
      checks++;
      if (act !== want) begin
        errors++;
        $display("[TB] FAIL %s (mode%s) got time=%h ht=%b le=%b want time=%h ht=%b le=%b",
                 cur.name, cur.sel12 ? "12" : "24", act[17:2], act[1], act[0],
                 want[17:2], want[1], want[0]);
      end
    end
  end

  // Queue an expectation for the selected instance.
  task automatic checkOutput(input string name, input bit sel12, input logic [15:0] t,
                             input logic ht, input logic le);
    exp_t e;
    e.name = name;
    e.sel12 = sel12;
    e.time_bcd = t;
    e.ht = ht;
    e.le = le;
    sb_q.push_back(e);
  endtask

  // One transaction: optional load and/or one-cycle minute pulse, then release.
  task automatic applyStimulus(input bit do_load, input bit do_tick, input logic [15:0] ld);
    @(posedge clk);
    #1;
    one_minute = do_tick;
    load_new_c = do_load;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = ld;
    @(posedge clk);
    #1;
    one_minute = 1'b0;
    load_new_c = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence.
  initial begin
    reset = 1'b1;
    one_minute = 1'b0;
    load_new_c = 1'b0;
    {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min} = 16'h0000;
    #1;
    checks++;
    if ({ms_hr_24, ls_hr_24, ms_min_24, ls_min_24, hour_tick_24, load_err_24} !== 18'h00000 ||
        {ms_hr_12, ls_hr_12, ms_min_12, ls_min_12, hour_tick_12, load_err_12} !== {16'h1200, 2'b00}) begin
      errors++;
      $display("[TB] FAIL reset_state got 24=%h%h:%h%h 12=%h%h:%h%h",
               ms_hr_24, ls_hr_24, ms_min_24, ls_min_24,
               ms_hr_12, ls_hr_12, ms_min_12, ls_min_12);
    end
    checkOutput("reset24", 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("reset12", 1'b1, 16'h1200, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000);
      checkOutput($sformatf("tick%0d", i), 1'b0, (i == 10) ? 16'h0010 : 16'(i), 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 16'h2359);
    checkOutput("load2359", 1'b0, 16'h2359, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("daywrap", 1'b0, 16'h0000, 1'b1, 1'b0);
    idleCycle();
    checkOutput("tickone", 1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("after_wrap", 1'b0, 16'h0001, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h0730);
    checkOutput("load0730", 1'b0, 16'h0730, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    one_minute = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("hold_first", 1'b0, 16'h0731, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    checkOutput("hold_end", 1'b0, 16'h0731, 1'b0, 1'b0);
    one_minute = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("reraise", 1'b0, 16'h0732, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h2400);
    checkOutput("bad2400", 1'b0, 16'h0732, 1'b0, 1'b1);
    idleCycle();
    checkOutput("err_one", 1'b0, 16'h0732, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h126A);
    checkOutput("bad126A", 1'b0, 16'h0732, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0945);
    checkOutput("load0945", 1'b0, 16'h0945, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 16'h0505);
    checkOutput("collide24", 1'b0, 16'h0505, 1'b0, 1'b0);
    checkOutput("collide12", 1'b1, 16'h0505, 1'b0, 1'b0);
    idleCycle();
    checkOutput("no_defer", 1'b0, 16'h0505, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h1542);
    checkOutput("load1542", 1'b0, 16'h1542, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    one_minute = 1'b1;
    #1;
    checks++;
    if ({ms_hr_24, ls_hr_24, ms_min_24, ls_min_24} !== 16'h0000 ||
        {ms_hr_12, ls_hr_12, ms_min_12, ls_min_12} !== 16'h1200) begin
      errors++;
      $display("[TB] FAIL async_reset got 24=%h%h:%h%h 12=%h%h:%h%h",
               ms_hr_24, ls_hr_24, ms_min_24, ls_min_24,
               ms_hr_12, ls_hr_12, ms_min_12, ls_min_12);
    end
    checkOutput("async24", 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("async12", 1'b1, 16'h1200, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("held_level24", 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("held_level12", 1'b1, 16'h1200, 1'b0, 1'b0);
    one_minute = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("post_rst24", 1'b0, 16'h0001, 1'b0, 1'b0);
    checkOutput("post_rst12", 1'b1, 16'h1201, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h1259);
    checkOutput("load1259", 1'b1, 16'h1259, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("wrap12to01", 1'b1, 16'h0100, 1'b1, 1'b0);
    checkOutput("wrap12to13", 1'b0, 16'h1300, 1'b1, 1'b0);
    idleCycle();
    checkOutput("tick12one", 1'b1, 16'h0100, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h0959);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("wrap09to10", 1'b1, 16'h1000, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h1159);
    applyStimulus(1'b0, 1'b1, 16'h0000);
    checkOutput("wrap11to12", 1'b1, 16'h1200, 1'b1, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h0030);
    checkOutput("bad0030_12", 1'b1, 16'h1200, 1'b0, 1'b1);
    checkOutput("ok0030_24", 1'b0, 16'h0030, 1'b0, 1'b0);
    idleCycle();
    checkOutput("err12one", 1'b1, 16'h1200, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
